// File: rtl/feature_buf_resp.sv
// Feature buffer: single-port-per-direction word store with a fixed-latency engine read path,
// engine-priority write arbitration against host loads, and saturating access statistics.
module feature_buf_resp #(
  parameter int unsigned DW     = 512,
  parameter int unsigned AW     = 11,
  parameter int unsigned DEPTH  = 1536,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_addr_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_data_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          host_wr_valid,
  output logic          host_wr_ready,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  input  logic          stat_clr,
  output logic [15:0]   rd_cnt,
  output logic [15:0]   wr_cnt,
  output logic          addr_err
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic          rd_in_range;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_in_range;
  logic          w_en;
  logic [DW-1:0] rd_fetch;

  logic [RD_LAT-1:0] vld_q;
  logic [DW-1:0]     dat_q [RD_LAT];
  logic [15:0]       rd_cnt_q;
  logic [15:0]       wr_cnt_q;
  logic              err_q;

  assign host_wr_ready = host_wr_valid & ~wr_data_valid;
  assign rd_in_range   = {1'b0, rd_addr} < DepthW;

  // Engine wins the single write port; a host write commits whenever the engine is idle.
  assign w_req      = wr_data_valid | host_wr_valid;
  assign w_addr     = wr_data_valid ? wr_addr : host_wr_addr;
  assign w_data     = wr_data_valid ? wr_data : host_wr_data;
  assign w_in_range = {1'b0, w_addr} < DepthW;
  assign w_en       = w_req & w_in_range & ~rst;

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Write-first: a same-cycle write to the read address forwards its data.
  always_comb begin
    rd_fetch = '0;
    if (rd_in_range) begin
      if (w_en && (w_addr == rd_addr)) begin
        rd_fetch = w_data;
      end else begin
        rd_fetch = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_addr_valid;
      dat_q[0] <= rd_addr_valid ? rd_fetch : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rd_data_valid = vld_q[RD_LAT-1];
  assign rd_data       = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (stat_clr) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (rd_addr_valid && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (w_en && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if ((rd_addr_valid && !rd_in_range) || (w_req && !w_in_range)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;
  assign addr_err = err_q;

endmodule

// File: doc/feature_buf_resp.md
FEATURE_BUF_RESP -- requirements
Module: feature_buf_resp

Interface
REQ-001 SHALL have parameter DW, default 512, giving the data word width in bits (16 x 32-bit lanes).
REQ-002 SHALL have parameter AW, default 11, giving the address width.
REQ-003 SHALL have parameter DEPTH, default 1536, giving the number of implemented words; valid addresses are 0..DEPTH-1.
REQ-004 SHALL have parameter RD_LAT, default 2, giving the cycles from read request to read data (legal values 1..4).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high (one clock; polarity and synchronicity fixed).
REQ-007 SHALL have port rd_addr_valid, input, 1 bit: engine read request.
REQ-008 SHALL have port rd_addr, input, AW bits: engine read address.
REQ-009 SHALL have port rd_data_valid, output, 1 bit: read data qualifier.
REQ-010 SHALL have port rd_data, output, DW bits: read data.
REQ-011 SHALL have port wr_data_valid, input, 1 bit: engine result write strobe.
REQ-012 SHALL have port wr_addr, input, AW bits: engine write address.
REQ-013 SHALL have port wr_data, input, DW bits: engine write data.
REQ-014 SHALL have port host_wr_valid, input, 1 bit: host load request.
REQ-015 SHALL have port host_wr_ready, output, 1 bit: host load accepted this cycle.
REQ-016 SHALL have port host_wr_addr, input, AW bits: host load address.
REQ-017 SHALL have port host_wr_data, input, DW bits: host load data.
REQ-018 SHALL have port stat_clr, input, 1 bit: synchronous clear of statistics and error flag.
REQ-019 SHALL have port rd_cnt, output, 16 bits: accepted engine reads.
REQ-020 SHALL have port wr_cnt, output, 16 bits: committed writes (engine plus host).
REQ-021 SHALL have port addr_err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-022 SHALL service every cycle with rd_addr_valid=1 (no backpressure), raising rd_data_valid exactly RD_LAT cycles later for one cycle per request; back-to-back requests SHALL yield back-to-back data in issue order.
REQ-023 SHALL drive rd_data=0 whenever rd_data_valid=0.
REQ-024 SHALL write memory when wr_data_valid=1; the engine has absolute priority over the host.
REQ-025 SHALL drive host_wr_ready = host_wr_valid & ~wr_data_valid (combinational); a host write commits only in a cycle with host_wr_valid=1 and host_wr_ready=1, and the host SHALL hold addr/data stable until then.
REQ-026 SHALL give a read issued in the same cycle as a committed write to the same address the new write data (write-first bypass); reads issued later SHALL see memory contents.
REQ-027 SHALL drop an engine read with rd_addr >= DEPTH from memory access: return rd_data=0 with rd_data_valid at normal latency, and set addr_err.
REQ-028 SHALL drop an engine or host write with address >= DEPTH: memory unchanged, the write not counted, addr_err set; an out-of-range host write still completes its handshake.
REQ-029 SHALL increment rd_cnt on each accepted read (including out-of-range reads) and wr_cnt on each committed in-range write; both SHALL saturate at 16'hFFFF (no wrap).
REQ-030 SHALL, on stat_clr=1, zero rd_cnt, wr_cnt and addr_err next cycle, ignoring same-cycle events; read and write traffic is unaffected.
REQ-031 SHALL implement the read pipeline as a RD_LAT-deep valid/data shift register behind the memory read; no other state machine.

Reset
REQ-032 SHALL, while rst=1, force rd_data_valid=0, rd_data=0, rd_cnt=0, wr_cnt=0 and addr_err=0, and flush all in-flight reads; host_wr_ready follows REQ-025.
REQ-033 SHALL leave memory contents undefined after reset; writes during rst=1 SHALL be ignored.
REQ-034 SHALL never return a response after reset deasserts for a read issued before reset asserted.

Verification
REQ-035 Bench SHALL cover: host writes 0xA5.. to addr 5, engine reads addr 5 at cycle t -> rd_data_valid=1 at t+2 with that data, rd_cnt=1, wr_cnt=1.
REQ-036 Bench SHALL cover: wr_data_valid and host_wr_valid both high for 3 cycles -> host_wr_ready=0 for all 3 cycles, host commits in the 4th cycle, wr_cnt=4.
REQ-037 Bench SHALL cover: same-cycle write of 0x1234.. and read of addr 100 -> rd_data=0x1234.. two cycles later.
REQ-038 Bench SHALL cover: read addr 1600 with DEPTH=1536 -> rd_data=0 with valid at t+2 and addr_err=1 until stat_clr.
REQ-039 Bench SHALL cover: reads at 100 consecutive cycles then rst pulsed mid-stream -> no rd_data_valid after reset releases, counters=0.
REQ-040 Bench SHALL cover: 65540 reads -> rd_cnt holds 16'hFFFF.
